// File: rtl/sseg_display_driver.sv
// ----------------------------------------------------------------------------
// sseg_display_driver
//
// Display stage for a binary counter. A captured binary VALUE is converted
// to four BCD digits by a sequential double-dabble (one shift per clock,
// VALUE_W clocks per conversion). The four digits are then time-multiplexed
// onto a 4-digit common-anode 7-segment display. Segment and anode outputs
// are active-low.
//
// A one-deep pending register holds a LOAD that arrives while a conversion
// is running. That value is converted back-to-back when the current
// conversion finishes.
//
// Parameters
//   VALUE_W      width of VALUE (1..13)
//   REFRESH_DIV  clock cycles each digit slot lasts (>= 2)
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   VALUE    in   binary value, sampled only when LOAD is high
//   LOAD     in   single-cycle strobe: capture VALUE and convert it
//   BUSY     out  conversion in progress
//   SSEGS    out  {dp,g,f,e,d,c,b,a}, active-low; dp is always off
//   AN       out  digit enables, active-low; AN[0] is the ones digit
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                          nonzero digit are blanked. Digit 0 is always
//                          shown. Scan timing does not change.
// ----------------------------------------------------------------------------
module sseg_display_driver #(
    parameter int unsigned VALUE_W     = 8,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [VALUE_W-1:0] VALUE,
    input  logic               LOAD,
    output logic               BUSY,
    output logic [7:0]         SSEGS,
    output logic [3:0]         AN
);

    localparam int unsigned CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned SH_W  = 16 + VALUE_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    typedef enum logic {
        StIdle,
        StConv
    } state_e;

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VALUE_W-1:0] pend_val_q, pend_val_d;
    logic               pend_vld_q, pend_vld_d;
    logic [15:0]        digits_q, digits_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    logic [15:0]        bcd_adj;
    logic [SH_W-1:0]    shifted;
    logic [3:0]         cur_digit;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        s = 8'hFF;
        unique case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // combined {bcd, bin} register left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Conversion FSM plus pending-load register.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        digits_d   = digits_q;

        unique case (state_q)
            StIdle: begin
                if (LOAD) begin
                    bin_d   = VALUE;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                bin_d = shifted[VALUE_W-1:0];
                bcd_d = shifted[SH_W-1 -: 16];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final shift: publish all four digits in one edge.
                    digits_d = shifted[SH_W-1 -: 16];
                    if (LOAD || pend_vld_q) begin
                        // A LOAD on this edge is newer than any pending value.
                        bin_d      = LOAD ? VALUE : pend_val_q;
                        bcd_d      = '0;
                        cnt_d      = '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (LOAD) begin
                    pend_val_d = VALUE;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Refresh timer, digit index and registered display outputs.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end

        cur_digit = digits_q[{idx_q, 2'b00} +: 4];
        an_d      = ~(4'b0001 << idx_q);
        seg_d     = seg_of(cur_digit);

`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic [3:0] shown;
            shown[3] = (digits_q[15:12] != 4'd0);
            shown[2] = shown[3] || (digits_q[11:8] != 4'd0);
            shown[1] = shown[2] || (digits_q[7:4] != 4'd0);
            shown[0] = 1'b1;
            if (!shown[idx_q]) begin
                an_d  = 4'b1111;
                seg_d = 8'hFF;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_val_q <= '0;
            pend_vld_q <= 1'b0;
            digits_q   <= '0;
            ref_q      <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            digits_q   <= digits_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign BUSY  = (state_q == StConv);
    assign AN    = an_q;
    assign SSEGS = seg_q;

endmodule

// File: tb/tb_sseg_display_driver.sv
// ----------------------------------------------------------------------------
// tb_sseg_display_driver
//
// Self-checking bench for sseg_display_driver with VALUE_W=8, REFRESH_DIV=4.
// Expected segment patterns are hand-computed per digit (digit 3 .. digit 0)
// in the vector table. Honours LEADING_ZERO_BLANK_EN when defined.
// ----------------------------------------------------------------------------
module tb_sseg_display_driver;

    localparam int unsigned VW = 8;
    localparam int unsigned RD = 4;

    logic          CLK     = 1'b0;
    logic          RESET_N = 1'b0;
    logic          LOAD    = 1'b0;
    logic [VW-1:0] VALUE   = '0;
    logic          BUSY;
    logic [7:0]    SSEGS;
    logic [3:0]    AN;

    int checks = 0;
    int errors = 0;

    sseg_display_driver #(
        .VALUE_W    (VW),
        .REFRESH_DIV(RD)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .VALUE  (VALUE),
        .LOAD   (LOAD),
        .BUSY   (BUSY),
        .SSEGS  (SSEGS),
        .AN     (AN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [VW-1:0] value;
        logic [31:0]   segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    localparam logic [31:0] SEGS_ZERO = 32'hC0C0C0C0;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Which digit slots are lit for a given set of digit patterns.
    function automatic logic [3:0] shown_mask(input logic [31:0] segs);
        logic [3:0] m;
        m[3] = (segs[31:24] != 8'hC0);
        m[2] = m[3] || (segs[23:16] != 8'hC0);
        m[1] = m[2] || (segs[15:8] != 8'hC0);
        m[0] = 1'b1;
`ifndef LEADING_ZERO_BLANK_EN
        m = 4'hF;
`endif
        return m;
    endfunction

    // Compare the current slot against the expected digit patterns.
    task automatic check_slot(input string name, input logic [31:0] segs, output int k);
        logic [3:0] m;
        m = shown_mask(segs);
        case (AN)
            4'b1110: k = 0;
            4'b1101: k = 1;
            4'b1011: k = 2;
            4'b0111: k = 3;
            4'b1111: k = -1;
            default: k = -2;
        endcase
        if (k >= 0) begin
            chk({name, " digit"}, {23'd0, m[k], SSEGS}, {23'd0, 1'b1, segs[k*8 +: 8]});
        end else if (k == -1) begin
            chk({name, " blank"}, {23'd0, |(~m), SSEGS}, {23'd0, 1'b1, 8'hFF});
        end else begin
            checks++;
            errors++;
            $display("FAIL %s onehot: AN=%b, required a single low bit", name, AN);
        end
    endtask

    // Let the new digits reach the outputs, then watch one full scan.
    task automatic scan_check(input string name, input logic [31:0] segs);
        logic [3:0] seen;
        int k;
        seen = 4'h0;
        tick();
        tick();
        for (int c = 0; c < 4 * RD; c++) begin
            check_slot(name, segs, k);
            if (k >= 0) seen[k] = 1'b1;
            tick();
        end
        chk({name, " seen"}, {28'd0, seen}, {28'd0, shown_mask(segs)});
    endtask

    // Called with RESET_N low: checks reset outputs, releases, and checks
    // the exact scan order and slot length against "0000".
    task automatic reset_scan(input string name);
        logic [3:0] m;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        int         idx;
        m = shown_mask(SEGS_ZERO);
        chk({name, " rst out"}, {19'd0, BUSY, AN, SSEGS}, {19'd0, 1'b0, 4'b1111, 8'hFF});
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            idx     = ((e - 1) / RD) % 4;
            exp_an  = m[idx] ? ~(4'b0001 << idx) : 4'b1111;
            exp_seg = m[idx] ? 8'hC0 : 8'hFF;
            chk($sformatf("%s scan e%0d", name, e), {19'd0, BUSY, AN, SSEGS},
                {19'd0, 1'b0, exp_an, exp_seg});
        end
    endtask

    task automatic load_value(input logic [VW-1:0] v);
        VALUE = v;
        LOAD  = 1'b1;
        tick();
        LOAD  = 1'b0;
        VALUE = ~v;  // must be ignored without LOAD
    endtask

    // First load, then up to two extra loads at given sample indices while
    // busy (0 = none). Busy must last two conversions back-to-back.
    task automatic two_load(input string name, input logic [VW-1:0] v0,
                            input logic [VW-1:0] va, input int na,
                            input logic [VW-1:0] vb, input int nb,
                            input logic [31:0] segs_mid, input logic [31:0] segs_fin);
        int n;
        int k;
        load_value(v0);
        n = 0;
        while (BUSY === 1'b1 && n < 60) begin
            n++;
            LOAD = 1'b0;
            if (n == na) begin
                VALUE = va;
                LOAD  = 1'b1;
            end
            if (n == nb) begin
                VALUE = vb;
                LOAD  = 1'b1;
            end
            if (n == 11) check_slot({name, " mid"}, segs_mid, k);
            tick();
        end
        LOAD = 1'b0;
        chk({name, " busy len"}, n, 16);
        scan_check({name, " final"}, segs_fin);
    endtask

    initial begin
        int n;

        vecs[0] = '{value: 8'd255, segs: 32'hC0A49292};
        vecs[1] = '{value: 8'd7,   segs: 32'hC0C0C0F8};
        vecs[2] = '{value: 8'd0,   segs: 32'hC0C0C0C0};
        vecs[3] = '{value: 8'd99,  segs: 32'hC0C09090};
        vecs[4] = '{value: 8'd128, segs: 32'hC0F9A480};
        vecs[5] = '{value: 8'd64,  segs: 32'hC0C08299};
        vecs[6] = '{value: 8'd10,  segs: 32'hC0C0F9C0};
        vecs[7] = '{value: 8'd100, segs: 32'hC0F9C0C0};

        // Reset and the idle scan of "0000".
        tick();
        tick();
        reset_scan("reset");

        // Table: each value converts in exactly VALUE_W busy cycles.
        for (int i = 0; i < 8; i++) begin
            load_value(vecs[i].value);
            n = 0;
            while (BUSY === 1'b1 && n < 60) begin
                n++;
                tick();
            end
            chk($sformatf("v%0d busy len", vecs[i].value), n, VW);
            scan_check($sformatf("v%0d", vecs[i].value), vecs[i].segs);
        end

        // Pending loads.
        two_load("pend 99/7", 8'd99, 8'd7, 2, 8'd0, 0, 32'hC0C09090, 32'hC0C0C0F8);
        two_load("pend overwrite", 8'd12, 8'd34, 3, 8'd56, 5, 32'hC0C0F9A4, 32'hC0C09282);
        two_load("load on done", 8'd5, 8'd3, 8, 8'd0, 0, 32'hC0C0C092, 32'hC0C0C0B0);

        // Reset in the middle of a conversion.
        load_value(8'd200);
        tick();
        tick();
        tick();
        #2;
        RESET_N = 1'b0;
        #1;
        reset_scan("mid reset");

        // Aborted conversion must not resurface.
        tick();
        chk("post reset busy", {31'd0, BUSY}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
